// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet output-side accumulator: FSM encoding,
// default lane widths and width-generic saturation / ReLU helpers.
package corelet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int PSUM_BW_DEF = 16;
  localparam int ACC_BW_DEF  = 24;
  localparam int WIDE_W      = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Helpers work on a wide signed carrier; callers narrow the result with a size cast.
  function automatic wide_t sat_hi(input int w);
    wide_t one;
    one = 64'sd1;
    return (one << (w - 1)) - one;
  endfunction

  function automatic wide_t sat_lo(input int w);
    wide_t one;
    one = 64'sd1;
    return -(one << (w - 1));
  endfunction

  function automatic logic sat_hit(input wide_t v, input int w);
    return (v > sat_hi(w)) || (v < sat_lo(w));
  endfunction

  function automatic wide_t sat_clamp(input wide_t v, input int w);
    wide_t r;
    r = v;
    if (v > sat_hi(w)) r = sat_hi(w);
    else if (v < sat_lo(w)) r = sat_lo(w);
    return r;
  endfunction

  function automatic wide_t relu(input wide_t v, input logic en);
    return (en && v[WIDE_W-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/corelet_acc_lane.sv
// One lane of the partial-sum accumulator: add with accumulator-width
// saturation, then ReLU and output-width saturation for the final pass.
module corelet_acc_lane
  import corelet_pkg::*;
#(
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int ACC_BW  = ACC_BW_DEF
) (
  input  logic signed [ACC_BW-1:0]  i_acc,
  input  logic signed [PSUM_BW-1:0] i_psum,
  input  logic                      i_first,
  input  logic                      i_final,
  input  logic                      i_relu,
  output logic signed [ACC_BW-1:0]  o_acc,
  output logic signed [PSUM_BW-1:0] o_out,
  output logic                      o_sat
);

  logic signed [ACC_BW:0]   w_sum;
  logic signed [ACC_BW-1:0] w_acc_new;
  logic signed [ACC_BW-1:0] w_relu;
  logic                     w_acc_hit;
  logic                     w_out_hit;

  // The first pass overwrites whatever a previous tile left in the entry.
  assign w_sum     = (ACC_BW+1)'(i_acc) + (ACC_BW+1)'(i_psum);
  assign w_acc_new = i_first ? ACC_BW'(i_psum) : ACC_BW'(sat_clamp(wide_t'(w_sum), ACC_BW));
  assign w_acc_hit = !i_first && sat_hit(wide_t'(w_sum), ACC_BW);

  assign w_relu    = ACC_BW'(relu(wide_t'(w_acc_new), i_relu));
  assign w_out_hit = i_final && sat_hit(wide_t'(w_relu), PSUM_BW);

  assign o_acc = w_acc_new;
  assign o_out = PSUM_BW'(sat_clamp(wide_t'(w_relu), PSUM_BW));
  assign o_sat = w_acc_hit || w_out_hit;

endmodule

// File: rtl/corelet_psum_acc.sv
// Multi-pass partial-sum accumulator with ReLU/saturation and a valid/ready output.
// Optional macro CORELET_PSUM_ACC_SAT_CNT_EN adds the 16-bit sat_cnt port.
module corelet_psum_acc
  import corelet_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int ACC_BW  = ACC_BW_DEF,
  parameter int DEPTH   = 16,
  parameter int PASS_BW = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PASS_BW-1:0]       cfg_num_pass,
  input  logic [$clog2(DEPTH):0]   cfg_depth,
  input  logic                     cfg_relu,
  input  logic [PSUM_BW*COL-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PSUM_BW*COL-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
`ifdef CORELET_PSUM_ACC_SAT_CNT_EN
  ,
  output logic [15:0]              sat_cnt
`endif
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [PASS_BW-1:0]       r_num_pass;
  logic [DW-1:0]            r_depth;
  logic                     r_relu;
  logic [PASS_BW-1:0]       r_pass;
  logic [AW-1:0]            r_addr;
  logic                     r_in_done;

  logic [PASS_BW-1:0]       w_num_pass_n;
  logic [DW-1:0]            w_depth_n;
  logic                     w_start;
  logic                     w_first;
  logic                     w_final;
  logic                     w_last_addr;
  logic                     w_xfer;
  logic                     w_last_out;

  logic [COL*ACC_BW-1:0]    r_acc_mem [DEPTH];
  logic [COL*ACC_BW-1:0]    w_acc_rd;
  logic [COL*ACC_BW-1:0]    w_acc_wr;
  logic [PSUM_BW*COL-1:0]   w_out_vec;
  logic [COL-1:0]           w_sat_lane;

  logic                     r_out_vld_p1;
  logic [PSUM_BW*COL-1:0]   r_out_data_p1;

  // Zero counts mean one; oversize depth clamps to the bank size.
  always_comb begin
    w_num_pass_n = (cfg_num_pass == '0) ? PASS_BW'(1) : cfg_num_pass;
    w_depth_n    = cfg_depth;
    if (cfg_depth == '0) w_depth_n = DW'(1);
    else if (cfg_depth > DW'(DEPTH)) w_depth_n = DW'(DEPTH);
  end

  assign w_start     = (r_state == ST_IDLE) && start;
  assign w_first     = (r_pass == '0);
  assign w_final     = (r_pass == r_num_pass - PASS_BW'(1));
  assign w_last_addr = (DW'(r_addr) == r_depth - DW'(1));
  assign w_xfer      = in_valid && in_ready;
  assign w_last_out  = r_out_vld_p1 && out_ready && r_in_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last_out) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // On the final pass the output register must be free (or draining) to accept more input.
  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE);
    in_ready = (r_state == ST_RUN) && !r_in_done &&
               (!w_final || !r_out_vld_p1 || out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_pass <= '0;
      r_depth    <= '0;
      r_relu     <= 1'b0;
      r_pass     <= '0;
      r_addr     <= '0;
      r_in_done  <= 1'b0;
    end else if (w_start) begin
      r_num_pass <= w_num_pass_n;
      r_depth    <= w_depth_n;
      r_relu     <= cfg_relu;
      r_pass     <= '0;
      r_addr     <= '0;
      r_in_done  <= 1'b0;
    end else if (w_xfer) begin
      if (w_last_addr) begin
        r_addr <= '0;
        if (w_final) r_in_done <= 1'b1;
        else         r_pass    <= r_pass + PASS_BW'(1);
      end else begin
        r_addr <= r_addr + AW'(1);
      end
    end
  end

  // ---- p0: accumulator read-modify-write ----
  assign w_acc_rd = r_acc_mem[r_addr];

  for (genvar g = 0; g < COL; g++) begin : g_lane
    corelet_acc_lane #(
      .PSUM_BW(PSUM_BW),
      .ACC_BW (ACC_BW)
    ) u_lane (
      .i_acc  (w_acc_rd[g*ACC_BW +: ACC_BW]),
      .i_psum (in_data[g*PSUM_BW +: PSUM_BW]),
      .i_first(w_first),
      .i_final(w_final),
      .i_relu (r_relu),
      .o_acc  (w_acc_wr[g*ACC_BW +: ACC_BW]),
      .o_out  (w_out_vec[g*PSUM_BW +: PSUM_BW]),
      .o_sat  (w_sat_lane[g])
    );
  end

  always_ff @(posedge clk) begin
    if (w_xfer) r_acc_mem[r_addr] <= w_acc_wr;
  end

  // ---- p1: output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_vld_p1  <= 1'b0;
      r_out_data_p1 <= '0;
    end else if (w_xfer && w_final) begin
      r_out_vld_p1  <= 1'b1;
      r_out_data_p1 <= w_out_vec;
    end else if (out_ready) begin
      r_out_vld_p1  <= 1'b0;
    end
  end

  assign out_valid = r_out_vld_p1;
  assign out_data  = r_out_data_p1;

`ifdef CORELET_PSUM_ACC_SAT_CNT_EN
  logic [15:0] r_sat_cnt;
  logic [16:0] w_sat_sum;

  always_comb begin
    w_sat_sum = {1'b0, r_sat_cnt};
    for (int i = 0; i < COL; i++) w_sat_sum = w_sat_sum + 17'(w_sat_lane[i]);
  end

  always_ff @(posedge clk) begin
    if (reset || w_start) r_sat_cnt <= '0;
    else if (w_xfer)      r_sat_cnt <= (w_sat_sum > 17'h0FFFF) ? 16'hFFFF : w_sat_sum[15:0];
  end

  assign sat_cnt = r_sat_cnt;
`else
  logic w_unused_sat;
  assign w_unused_sat = ^w_sat_lane;
`endif

endmodule

// File: tb/tb_corelet_psum_acc.sv
// Directed self-checking bench for corelet_psum_acc (default 8 lanes x 16 bit).
module tb_corelet_psum_acc;

  localparam int COL = 8;
  localparam int PW  = 16;
  localparam int W   = COL * PW;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   cfg_num_pass = '0;
  logic [4:0]   cfg_depth = '0;
  logic         cfg_relu = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         done;
`ifdef CORELET_PSUM_ACC_SAT_CNT_EN
  logic [15:0]  sat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  corelet_psum_acc #(
    .COL(8), .PSUM_BW(16), .ACC_BW(24), .DEPTH(16), .PASS_BW(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_num_pass(cfg_num_pass), .cfg_depth(cfg_depth), .cfg_relu(cfg_relu),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
`ifdef CORELET_PSUM_ACC_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] splat(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] lanes2(input int a, input int b);
    logic [W-1:0] r;
    r = '0;
    r[PW-1:0]    = PW'(a);
    r[2*PW-1:PW] = PW'(b);
    return r;
  endfunction

  task automatic start_tile(input int np, input int d, input logic relu);
    cfg_num_pass = 4'(np);
    cfg_depth    = 5'(d);
    cfg_relu     = relu;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Present one vector and wait (bounded) until it is taken.
  task automatic send(input string tag, input logic [W-1:0] v);
    int n;
    n = 0;
    in_data  = v;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_accept"}, W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] v);
    chk({tag, "_vld"}, W'(out_valid), W'(1));
    chk({tag, "_data"}, out_data, v);
  endtask

  task automatic finish_tile(input string tag);
    tick();
    chk({tag, "_done"}, W'(done), W'(1));
    tick();
    chk({tag, "_idle"}, W'({done, busy}), W'(0));
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_data", out_data, '0);

    // in_valid while idle has no effect
    in_valid = 1'b1;
    in_data  = splat(9);
    tick();
    chk("idle_in_ready", W'(in_ready), W'(0));
    chk("idle_out_valid", W'(out_valid), W'(0));
    in_valid = 1'b0;

    // Basic accumulation: 3 passes x 2 entries of 5
    start_tile(3, 2, 1'b0);
    chk("basic_busy", W'(busy), W'(1));
    send("b0", splat(5));
    send("b1", splat(5));
    send("b2", splat(5));
    send("b3", splat(5));
    chk("basic_no_early_out", W'(out_valid), W'(0));
    send("b4", splat(5));
    expect_out("basic_out0", splat(15));
    send("b5", splat(5));
    expect_out("basic_out1", splat(15));
    finish_tile("basic");

    // ReLU on and off
    start_tile(2, 1, 1'b1);
    send("r0", lanes2(-10, 4));
    send("r1", lanes2(3, 4));
    expect_out("relu_on", lanes2(0, 8));
    finish_tile("relu_on");
    start_tile(2, 1, 1'b0);
    send("r2", lanes2(-10, 4));
    send("r3", lanes2(3, 4));
    expect_out("relu_off", lanes2(-7, 8));
    finish_tile("relu_off");

    // Output saturation, positive and negative
    start_tile(4, 1, 1'b0);
    for (int i = 0; i < 4; i++) send("sp", splat(32767));
    expect_out("sat_pos", splat(32767));
`ifdef CORELET_PSUM_ACC_SAT_CNT_EN
    chk("sat_cnt_pos", W'(sat_cnt), W'(8));
`endif
    finish_tile("sat_pos");
    start_tile(4, 1, 1'b0);
    for (int i = 0; i < 4; i++) send("sn", splat(-32768));
    expect_out("sat_neg", splat(-32768));
`ifdef CORELET_PSUM_ACC_SAT_CNT_EN
    chk("sat_cnt_neg", W'(sat_cnt), W'(8));
`endif
    finish_tile("sat_neg");

    // Backpressure on the final pass
    out_ready = 1'b0;
    start_tile(1, 3, 1'b0);
    send("bp0", splat(1));
    expect_out("bp_first", splat(1));
    in_data  = splat(2);
    in_valid = 1'b1;
    #1;
    chk("bp_blocked", W'(in_ready), W'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", out_data, splat(1));
      chk("bp_hold_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", W'(in_ready), W'(1));
    tick();
    expect_out("bp_second", splat(2));
    in_data = splat(3);
    tick();
    expect_out("bp_third", splat(3));
    in_valid = 1'b0;
    tick();
    chk("bp_done", W'(done), W'(1));
    tick();

    // num_pass = 0 and depth = 0 both act as 1
    start_tile(0, 1, 1'b0);
    send("np0", splat(7));
    expect_out("np0_out", splat(7));
    finish_tile("np0");
    start_tile(1, 0, 1'b0);
    send("d0", splat(-3));
    expect_out("d0_out", splat(-3));
    finish_tile("d0");

    // Oversize depth clamps to 16 entries
    start_tile(1, 21, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send("dc", splat(i + 100));
      expect_out("dclamp_out", splat(i + 100));
    end
    finish_tile("dclamp");

    // Reset mid-tile drops pending output
    start_tile(2, 2, 1'b0);
    send("m0", splat(100));
    send("m1", splat(100));
    send("m2", splat(1));
    expect_out("mid_out", splat(101));
    reset = 1'b1;
    tick();
    chk("mid_rst_vld", W'(out_valid), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_ready", W'(in_ready), W'(0));
    reset = 1'b0;

    // Fresh tile ignores stale entries and a start pulse while running
    start_tile(2, 2, 1'b0);
    send("n0", splat(2));
    start_tile(1, 1, 1'b1);
    chk("restart_busy", W'(busy), W'(1));
    send("n1", splat(3));
    chk("restart_ignored", W'(out_valid), W'(0));
    send("n2", splat(4));
    expect_out("new_out0", splat(6));
    send("n3", splat(5));
    expect_out("new_out1", splat(8));
    finish_tile("new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
